// File: rtl/clksw_sequencer.sv
// rtl/clksw_sequencer.sv - hsclk_sel request sequencer for the PHI2-stopping clock switcher
// Owns the fast/host clock decision, divider selection, low-speed dwell and handshake timeouts.
module clksw_sequencer #(
  parameter int HOLDOFF_CYCLES = 2,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic       lsclk_in,
  input  logic       rst_b,
  input  logic       fast_en,
  input  logic       host_req,
  input  logic [1:0] div_cfg,
  input  logic       err_clr,
  input  logic       hsclk_selected,
  input  logic       lsclk_selected,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       in_fast,
  output logic       switch_err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    LS_RUN = 2'b00,
    HS_REQ = 2'b01,
    HS_RUN = 2'b10,
    LS_REQ = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_TGT = CNT_W'(HOLDOFF_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state_q, state_d;
  logic             hs_meta, hs_sync;
  logic [CNT_W-1:0] holdoff_cnt, holdoff_d, holdoff_inc;
  logic [CNT_W-1:0] timeout_cnt, timeout_d, timeout_inc;
  logic             hs_sel_d;
  logic [1:0]       div_d;
  logic             err_set;
  logic             holdoff_done, timeout_hit, leave_fast;

  assign holdoff_inc  = (holdoff_cnt == CNT_MAX) ? holdoff_cnt : holdoff_cnt + 1'b1;
  assign timeout_inc  = (timeout_cnt == CNT_MAX) ? timeout_cnt : timeout_cnt + 1'b1;
  assign holdoff_done = (holdoff_cnt >= HOLD_TGT);
  // Hit on the edge that completes the TIMEOUT_CYCLES-th cycle spent waiting.
  assign timeout_hit  = (timeout_cnt == TO_LAST);
  assign leave_fast   = host_req | ~fast_en;

  always_comb begin
    state_d   = state_q;
    hs_sel_d  = hsclk_sel;
    div_d     = cpuclk_div_sel;
    holdoff_d = holdoff_cnt;
    timeout_d = timeout_cnt;
    err_set   = 1'b0;
    case (state_q)
      LS_RUN: begin
        holdoff_d = holdoff_inc;
        if (holdoff_done && !hs_sync)
          div_d = div_cfg[1] ? 2'b10 : div_cfg;
        if (fast_en && !host_req && holdoff_done && lsclk_selected && !hs_sync) begin
          state_d   = HS_REQ;
          hs_sel_d  = 1'b1;
          timeout_d = '0;
        end
      end
      HS_REQ: begin
        timeout_d = timeout_inc;
        if (leave_fast) begin
          state_d   = LS_REQ;
          hs_sel_d  = 1'b0;
          timeout_d = '0;
        end else if (hs_sync) begin
          state_d = HS_RUN;
        end else if (timeout_hit) begin
          err_set   = 1'b1;
          state_d   = LS_REQ;
          hs_sel_d  = 1'b0;
          timeout_d = '0;
        end
      end
      HS_RUN: begin
        if (leave_fast || !hs_sync) begin
          err_set   = !leave_fast;
          state_d   = LS_REQ;
          hs_sel_d  = 1'b0;
          timeout_d = '0;
        end
      end
      LS_REQ: begin
        // hsclk_sel stays low here until the switcher confirms the low-speed clock.
        timeout_d = timeout_inc;
        if (lsclk_selected && !hs_sync) begin
          state_d   = LS_RUN;
          holdoff_d = '0;
        end else if (timeout_hit) begin
          err_set = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge lsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= LS_RUN;
      hsclk_sel      <= 1'b0;
      cpuclk_div_sel <= 2'b00;
      in_fast        <= 1'b0;
      switch_err     <= 1'b0;
      hs_meta        <= 1'b0;
      hs_sync        <= 1'b0;
      holdoff_cnt    <= '0;
      timeout_cnt    <= '0;
    end else begin
      state_q        <= state_d;
      hsclk_sel      <= hs_sel_d;
      cpuclk_div_sel <= div_d;
      in_fast        <= (state_d == HS_RUN);
      switch_err     <= err_set | (switch_err & ~err_clr);
      hs_meta        <= hsclk_selected;
      hs_sync        <= hs_meta;
      holdoff_cnt    <= holdoff_d;
      timeout_cnt    <= timeout_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_clksw_sequencer.sv
// tb/tb_clksw_sequencer.sv - directed self-checking bench for clksw_sequencer
// Switcher acknowledges are driven by hand so every expected value is cycle-exact.
module tb_clksw_sequencer;

  logic       lsclk_in = 1'b0;
  logic       rst_b;
  logic       fast_en;
  logic       host_req;
  logic [1:0] div_cfg;
  logic       err_clr;
  logic       hsclk_selected;
  logic       lsclk_selected;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       in_fast;
  logic       switch_err;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  clksw_sequencer dut (
    .lsclk_in       (lsclk_in),
    .rst_b          (rst_b),
    .fast_en        (fast_en),
    .host_req       (host_req),
    .div_cfg        (div_cfg),
    .err_clr        (err_clr),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .in_fast        (in_fast),
    .switch_err     (switch_err),
    .state          (state)
  );

  always #5 lsclk_in = ~lsclk_in;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge lsclk_in);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_b = 1'b0; fast_en = 1'b1; host_req = 1'b0; div_cfg = 2'b00; err_clr = 1'b0;
    hsclk_selected = 1'b0; lsclk_selected = 1'b1;
    #12;
    check("rst_state", 4'(state), 4'h0);
    check("rst_hsclk_sel", 4'(hsclk_sel), 4'h0);
    check("rst_div", 4'(cpuclk_div_sel), 4'h0);
    check("rst_in_fast", 4'(in_fast), 4'h0);
    check("rst_err", 4'(switch_err), 4'h0);
    rst_b = 1'b1;

    // Holdoff dwell then first fast request on edge 3
    tick(2);
    check("dwell_sel", 4'(hsclk_sel), 4'h0);
    check("dwell_state", 4'(state), 4'h0);
    tick(1);
    check("req_sel", 4'(hsclk_sel), 4'h1);
    check("req_state", 4'(state), 4'h1);
    tick(3);
    hsclk_selected = 1'b1; lsclk_selected = 1'b0;
    tick(2);
    check("sync_wait_state", 4'(state), 4'h1);
    check("sync_wait_fast", 4'(in_fast), 4'h0);
    tick(1);
    check("hs_run_state", 4'(state), 4'h2);
    check("hs_run_fast", 4'(in_fast), 4'h1);

    // Divider change deferred while fast; host_req pulse drops back
    div_cfg = 2'b01;
    tick(2);
    check("div_frozen", 4'(cpuclk_div_sel), 4'h0);
    host_req = 1'b1;
    tick(1);
    host_req = 1'b0;
    check("ls_req_state", 4'(state), 4'h3);
    check("ls_req_sel", 4'(hsclk_sel), 4'h0);
    check("ls_req_fast", 4'(in_fast), 4'h0);
    tick(1);
    hsclk_selected = 1'b0;
    tick(2);
    check("ls_wait_state", 4'(state), 4'h3);
    lsclk_selected = 1'b1;
    tick(1);
    check("ls_run_state", 4'(state), 4'h0);
    check("ls_run_div", 4'(cpuclk_div_sel), 4'h0);
    tick(2);
    check("redwell_sel", 4'(hsclk_sel), 4'h0);
    check("redwell_div", 4'(cpuclk_div_sel), 4'h0);
    tick(1);
    check("rereq_sel", 4'(hsclk_sel), 4'h1);
    check("div_applied", 4'(cpuclk_div_sel), 4'h1);

    // host_req and hs_sync both high in HS_REQ: abort wins
    hsclk_selected = 1'b1; lsclk_selected = 1'b0;
    tick(2);
    check("race_pre_state", 4'(state), 4'h1);
    host_req = 1'b1;
    tick(1);
    check("race_state", 4'(state), 4'h3);
    check("race_fast", 4'(in_fast), 4'h0);
    check("race_sel", 4'(hsclk_sel), 4'h0);
    host_req = 1'b0; hsclk_selected = 1'b0;
    tick(2);
    lsclk_selected = 1'b1;
    tick(1);
    check("race_back_state", 4'(state), 4'h0);

    // Switcher never acknowledges: HS_REQ timeout
    div_cfg = 2'b11;
    tick(3);
    check("div_by4", 4'(cpuclk_div_sel), 4'h2);
    check("to_req_state", 4'(state), 4'h1);
    tick(14);
    check("to_pre_err", 4'(switch_err), 4'h0);
    check("to_pre_state", 4'(state), 4'h1);
    tick(1);
    check("to_err", 4'(switch_err), 4'h1);
    check("to_state", 4'(state), 4'h3);
    check("to_sel", 4'(hsclk_sel), 4'h0);
    tick(1);
    check("to_back_state", 4'(state), 4'h0);
    check("to_err_sticky", 4'(switch_err), 4'h1);
    err_clr = 1'b1;
    tick(1);
    check("err_cleared", 4'(switch_err), 4'h0);
    err_clr = 1'b0;

    // Second timeout with err_clr on the same edge: set wins
    tick(16);
    check("to2_pre_state", 4'(state), 4'h1);
    err_clr = 1'b1; lsclk_selected = 1'b0;
    tick(1);
    check("set_clr_err", 4'(switch_err), 4'h1);
    check("set_clr_state", 4'(state), 4'h3);
    tick(1);
    check("err_cleared2", 4'(switch_err), 4'h0);
    err_clr = 1'b0;

    // LS_REQ timeout flags an error but waits for the acknowledge
    tick(13);
    check("lsto_pre_err", 4'(switch_err), 4'h0);
    check("lsto_pre_state", 4'(state), 4'h3);
    tick(1);
    check("lsto_err", 4'(switch_err), 4'h1);
    check("lsto_state", 4'(state), 4'h3);
    check("lsto_sel", 4'(hsclk_sel), 4'h0);
    lsclk_selected = 1'b1;
    tick(1);
    check("lsto_back_state", 4'(state), 4'h0);

    // Asynchronous reset in HS_RUN
    tick(3);
    check("rr_req_state", 4'(state), 4'h1);
    check("rr_div", 4'(cpuclk_div_sel), 4'h2);
    hsclk_selected = 1'b1; lsclk_selected = 1'b0;
    tick(3);
    check("rr_run_state", 4'(state), 4'h2);
    check("rr_run_fast", 4'(in_fast), 4'h1);
    #2;
    rst_b = 1'b0;
    #1;
    check("arst_sel", 4'(hsclk_sel), 4'h0);
    check("arst_fast", 4'(in_fast), 4'h0);
    check("arst_div", 4'(cpuclk_div_sel), 4'h0);
    check("arst_state", 4'(state), 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
